// File: rtl/ip_job_sequencer.sv
// ip_job_sequencer: drives the stream IP en/command pins for software jobs
// (load, unload, load+unload), tracks DMA_VALID handshakes and beat counts.
// Ports: clk, rst (sync, active-low); ctrl_en/start/mode job control;
//   dma_valid, s_valid/s_ready, m_valid/m_ready/m_tlast observe the IP;
//   en/command drive the IP; busy/done/err/in_cnt/out_cnt report status.
module ip_job_sequencer #(
    parameter int DEPTH    = 32,
    parameter int CNT_W    = 6,
    parameter int CMD_HOLD = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_en,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             dma_valid,
    input  logic             s_valid,
    input  logic             s_ready,
    input  logic             m_valid,
    input  logic             m_ready,
    input  logic             m_tlast,
    output logic             en,
    output logic [1:0]       command,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] out_cnt
);
    localparam int HOLD_W = $clog2(CMD_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CMD_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_OFF, S_IDLE, S_LCMD, S_LOAD, S_LWLO, S_LWHI,
        S_UCMD, S_UNLOAD, S_UWLO, S_UWHI, S_DONE, S_ERR
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold;
    logic [TMO_W-1:0]  tmo;
    logic [1:0]        job_mode;
    logic              fresh;
    logic              s_beat;
    logic              m_beat;
    logic              timed;
    logic              progress;

    assign s_beat = s_valid & s_ready;
    assign m_beat = m_valid & m_ready;

    // Watchdog applies to data and DMA wait states; any forward step
    // (beat or DMA edge) restarts it.
    always_comb begin
        timed    = 1'b0;
        progress = 1'b0;
        case (state)
            S_LOAD:         begin timed = 1'b1; progress = s_beat;     end
            S_UNLOAD:       begin timed = 1'b1; progress = m_beat;     end
            S_LWLO, S_UWLO: begin timed = 1'b1; progress = !dma_valid; end
            S_LWHI, S_UWHI: begin timed = 1'b1; progress = dma_valid;  end
            default:        ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_OFF;
            en       <= 1'b0;
            command  <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 2'd0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            hold     <= '0;
            tmo      <= '0;
            job_mode <= 2'd0;
            fresh    <= 1'b0;
        end else if (!ctrl_en) begin
            state   <= S_OFF;
            en      <= 1'b0;
            command <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 2'd0;
            hold    <= '0;
            tmo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_OFF: begin
                    state <= S_IDLE;
                    en    <= 1'b1;
                    fresh <= 1'b1;
                end
                S_IDLE: if (start && mode != 2'd0) begin
                    job_mode <= mode;
                    in_cnt   <= '0;
                    out_cnt  <= '0;
                    busy     <= 1'b1;
                    hold     <= '0;
                    tmo      <= '0;
                    if (!mode[0]) begin
                        state   <= S_UCMD;
                        command <= 2'd2;
                    end else if (fresh) begin
                        // freshly enabled IP enters load on DMA_VALID alone
                        state <= S_LOAD;
                        fresh <= 1'b0;
                    end else begin
                        state   <= S_LCMD;
                        command <= 2'd1;
                    end
                end
                S_LCMD, S_UCMD: begin
                    if (hold == HOLD_LAST) begin
                        state   <= (state == S_LCMD) ? S_LOAD : S_UNLOAD;
                        command <= 2'd0;
                        hold    <= '0;
                        tmo     <= '0;
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                end
                S_LOAD: if (s_beat) begin
                    if (in_cnt != DEPTH_C) in_cnt <= in_cnt + CNT_W'(1);
                    if (in_cnt == LAST_BEAT) state <= S_LWLO;
                end
                S_LWLO: if (!dma_valid) state <= S_LWHI;
                S_LWHI: if (dma_valid) begin
                    if (job_mode == 2'd3) begin
                        state   <= S_UCMD;
                        command <= 2'd2;
                        hold    <= '0;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_UNLOAD: if (m_beat) begin
                    if (out_cnt != DEPTH_C) out_cnt <= out_cnt + CNT_W'(1);
                    if (m_tlast) begin
                        if (out_cnt == LAST_BEAT) begin
                            state <= S_UWLO;
                        end else begin
                            state <= S_ERR;
                            err   <= 2'd2;
                            busy  <= 1'b0;
                        end
                    end else if (out_cnt == LAST_BEAT) begin
                        state <= S_ERR;
                        err   <= 2'd3;
                        busy  <= 1'b0;
                    end
                end
                S_UWLO: if (!dma_valid) state <= S_UWHI;
                S_UWHI: if (dma_valid) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_ERR:   command <= 2'd0;
                default: state <= S_OFF;
            endcase
            if (timed) begin
                if (progress) begin
                    tmo <= '0;
                end else if (tmo == TMO_LAST) begin
                    state <= S_ERR;
                    err   <= 2'd1;
                    busy  <= 1'b0;
                end else begin
                    tmo <= tmo + TMO_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ip_job_sequencer.sv
// tb_ip_job_sequencer: randomized job traffic against ip_job_sequencer with
// a queue-based scoreboard for done/err events and command pulses.
module tb_ip_job_sequencer;
    localparam int DEPTH    = 32;
    localparam int CNT_W    = 6;
    localparam int CMD_HOLD = 4;
    localparam int TIMEOUT  = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             ctrl_en;
    logic             start;
    logic [1:0]       mode;
    logic             dma_valid;
    logic             s_valid;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic             m_tlast;
    logic             en;
    logic [1:0]       command;
    logic             busy;
    logic             done;
    logic [1:0]       err;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;

    ip_job_sequencer #(
        .DEPTH(DEPTH), .CNT_W(CNT_W),
        .CMD_HOLD(CMD_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .start(start),
        .mode(mode), .dma_valid(dma_valid),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_tlast(m_tlast),
        .en(en), .command(command), .busy(busy), .done(done),
        .err(err), .in_cnt(in_cnt), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = done pulse, 1 = error raised
    typedef struct { int kind; int code; int icnt; int ocnt; int at; } ev_t;
    typedef struct { int val; int len; } cmd_t;

    ev_t  evq[$];
    cmd_t cmdq[$];
    int   tests = 0;
    int   fails = 0;
    bit   fresh_m = 1'b0;
    int   last_act = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int code,
                           input int icnt, input int ocnt, input int at);
        ev_t e;
        e.kind = kind; e.code = code;
        e.icnt = icnt; e.ocnt = ocnt; e.at = at;
        evq.push_back(e);
    endtask

    task automatic push_cmd(input int val);
        cmd_t c;
        c.val = val;
        c.len = CMD_HOLD;
        cmdq.push_back(c);
    endtask

    initial begin : monitor
        ev_t  e;
        cmd_t c;
        int   prev_cmd;
        int   run_len;
        int   prev_err;
        prev_cmd = 0;
        run_len  = 0;
        prev_err = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (evq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = evq.pop_front();
                    chk("done_kind", 0, e.kind);
                    chk("done_cycle", cyc, e.at);
                    chk("done_in_cnt", int'(in_cnt), e.icnt);
                    chk("done_out_cnt", int'(out_cnt), e.ocnt);
                    chk("done_busy", int'(busy), 1);
                end
            end
            if (err != 2'd0 && prev_err == 0) begin
                if (evq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL err_unexpected: got err=%0d, expected 0 (cycle %0d)", err, cyc);
                end else begin
                    e = evq.pop_front();
                    chk("err_kind", 1, e.kind);
                    chk("err_code", int'(err), e.code);
                    chk("err_cycle", cyc, e.at);
                    chk("err_busy", int'(busy), 0);
                end
            end
            prev_err = int'(err);
            if (int'(command) == prev_cmd && prev_cmd != 0) begin
                run_len++;
            end else begin
                if (prev_cmd != 0) begin
                    if (cmdq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL cmd_unexpected: got command=%0d for %0d cycles, expected none", prev_cmd, run_len);
                    end else begin
                        c = cmdq.pop_front();
                        chk("cmd_value", prev_cmd, c.val);
                        chk("cmd_len", run_len, c.len);
                    end
                end
                run_len = (command != 2'd0) ? 1 : 0;
            end
            prev_cmd = int'(command);
        end
    end

    task automatic start_job(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = 2'($urandom);
        if (m == 2'd0) return;
        if (m[0]) begin
            if (fresh_m) begin
                fresh_m = 1'b0;
            end else begin
                push_cmd(1);
                repeat (CMD_HOLD) tick();
            end
        end else begin
            push_cmd(2);
            repeat (CMD_HOLD) tick();
        end
    endtask

    task automatic load_phase(input int stall_at, output bit stalled);
        int cnt = 0;
        stalled  = 1'b0;
        last_act = cyc;
        while (cnt < DEPTH) begin
            if (cnt == stall_at) begin
                s_valid = 1'b0; start = 1'b0; m_valid = 1'b0;
                push_ev(1, 1, 0, 0, last_act + TIMEOUT);
                repeat (TIMEOUT + 4) tick();
                stalled = 1'b1;
                return;
            end
            s_valid = ($urandom_range(0, 3) != 0);
            s_ready = ($urandom_range(0, 2) != 0);
            m_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            m_tlast = 1'($urandom_range(0, 1));
            start   = ($urandom_range(0, 15) == 0);
            mode    = 2'($urandom);
            tick();
            if (s_valid && s_ready) begin
                cnt++;
                last_act = cyc;
            end
        end
        s_valid = 1'b0; start = 1'b0; m_valid = 1'b0; m_tlast = 1'b0;
    endtask

    task automatic dma_phase();
        dma_valid = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        dma_valid = 1'b1;
        tick();
    endtask

    // res: 0 completed, 1 protocol error, 2 aborted by ctrl_en
    task automatic unload_phase(input int tl_at, input int abort_at,
                                output int res);
        int cnt = 0;
        res = 0;
        while (cnt < DEPTH) begin
            if (cnt == abort_at) begin
                m_valid = 1'b0;
                ctrl_en = 1'b0;
                tick();
                chk("abort_en", int'(en), 0);
                chk("abort_cmd", int'(command), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_err", int'(err), 0);
                ctrl_en = 1'b1;
                tick();
                chk("reenable_en", int'(en), 1);
                fresh_m = 1'b1;
                res = 2;
                return;
            end
            m_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            m_tlast = (cnt + 1 == tl_at);
            s_valid = 1'($urandom_range(0, 1));
            s_ready = 1'($urandom_range(0, 1));
            tick();
            if (m_valid && m_ready) begin
                cnt++;
                if (m_tlast && cnt < DEPTH) begin
                    push_ev(1, 2, 0, 0, cyc);
                    res = 1;
                    break;
                end
                if (!m_tlast && cnt == DEPTH) begin
                    push_ev(1, 3, 0, 0, cyc);
                    res = 1;
                end
            end
        end
        m_valid = 1'b0; m_tlast = 1'b0; s_valid = 1'b0;
    endtask

    task automatic recover(input int code);
        repeat (3) tick();
        chk("err_hold", int'(err), code);
        chk("err_state_busy", int'(busy), 0);
        chk("err_state_en", int'(en), 1);
        chk("err_state_cmd", int'(command), 0);
        start = 1'b1;
        mode  = 2'd1;
        tick();
        start = 1'b0;
        chk("err_sticky", int'(err), code);
        ctrl_en = 1'b0;
        tick();
        chk("off_en", int'(en), 0);
        chk("off_err", int'(err), 0);
        ctrl_en = 1'b1;
        tick();
        chk("on_en", int'(en), 1);
        chk("on_busy", int'(busy), 0);
        fresh_m = 1'b1;
    endtask

    task automatic run_job(input logic [1:0] m, input int stall_at,
                           input int tl_at, input int abort_at);
        bit stalled;
        int res;
        start_job(m);
        if (m == 2'd0) begin
            tick();
            chk("noop_busy", int'(busy), 0);
            return;
        end
        chk("job_busy", int'(busy), 1);
        if (m[0]) begin
            load_phase(stall_at, stalled);
            if (stalled) begin
                recover(1);
                return;
            end
            dma_phase();
            if (m == 2'd1) begin
                push_ev(0, 0, DEPTH, 0, cyc);
                repeat (2) tick();
                return;
            end
            push_cmd(2);
            repeat (CMD_HOLD) tick();
        end
        unload_phase(tl_at, abort_at, res);
        if (res == 1) begin
            recover(tl_at == 0 ? 3 : 2);
            return;
        end
        if (res == 2) return;
        dma_phase();
        push_ev(0, 0, m[0] ? DEPTH : 0, DEPTH, cyc);
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int st;
        int tl;
        int ab;
        int r;
        logic [1:0] m;
        rst = 1'b0; ctrl_en = 1'b0; start = 1'b0; mode = 2'd0;
        dma_valid = 1'b1; s_valid = 1'b0; s_ready = 1'b0;
        m_valid = 1'b0; m_ready = 1'b0; m_tlast = 1'b0;
        repeat (5) tick();
        chk("rst_en", int'(en), 0);
        chk("rst_cmd", int'(command), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_in_cnt", int'(in_cnt), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        ctrl_en = 1'b1;
        tick();
        chk("rst_holds_en", int'(en), 0);
        rst = 1'b1;
        tick();
        chk("enable_en", int'(en), 1);
        chk("enable_busy", int'(busy), 0);
        fresh_m = 1'b1;
        tick();
        run_job(2'd1, -1, DEPTH, -1);
        run_job(2'd3, -1, DEPTH, -1);
        run_job(2'd2, -1, 20, -1);
        run_job(2'd1, 10, DEPTH, -1);
        run_job(2'd2, -1, DEPTH, 5);
        run_job(2'd0, -1, DEPTH, -1);
        run_job(2'd2, -1, 0, -1);
        run_job(2'd3, -1, DEPTH, -1);
        for (int j = 0; j < 24; j++) begin
            m  = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            st = -1;
            tl = DEPTH;
            ab = -1;
            if (r == 0) st = $urandom_range(0, DEPTH - 1);
            if (r == 1) tl = $urandom_range(1, DEPTH - 1);
            if (r == 2) tl = 0;
            if (r == 3) ab = $urandom_range(0, DEPTH - 1);
            run_job(m, st, tl, ab);
        end
        repeat (10) tick();
        chk("events_drained", evq.size(), 0);
        chk("cmds_drained", cmdq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
